// File: rtl/square1_anim_sequencer_if.sv
// Control and output bundle between the animation sequencer and the
// diagonal-trail pattern datapath / its control source.
`timescale 1ns/1ps
interface square1_anim_sequencer_if #(
  parameter int FRAME_W = 9
);
  logic               frame_tick;
  logic               pause;
  logic               step;
  logic               dir;
  logic [1:0]         speed;
  logic [FRAME_W-1:0] frame_no;
  logic [3:0]         trail_len;
  logic               advance;
  logic [1:0]         state;

  modport master (
    output frame_tick, pause, step, dir, speed,
    input  frame_no, trail_len, advance, state
  );

  modport slave (
    input  frame_tick, pause, step, dir, speed,
    output frame_no, trail_len, advance, state
  );
endinterface

// File: rtl/square1_anim_sequencer.sv
// Frame-rate scheduler for the diagonal-trail VGA pattern.
// Owns the animation frame counter and trail length; runs an intro in
// which the trail grows, then RUN / PAUSED with single-step.
// Optional: define SQUARE1_AUTO_REVERSE_EN for ping-pong animation
// (frame_no bounces at the ends of its range instead of wrapping).
`timescale 1ns/1ps
module square1_anim_sequencer #(
  parameter int FRAME_W     = 9,
  parameter int N_LAG       = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  square1_anim_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    INTRO   = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  // {pause, step, dir, speed[1:0]} travel together through the synchronizer
  logic [4:0]         sync_q [SYNC_STAGES];
  logic               pause_s, step_s, dir_s;
  logic [1:0]         speed_s;
  logic               step_prev;
  logic               step_req;

  state_t             state_q, state_d;
  logic [2:0]         div_q, div_d, div_lim;
  logic               div_hit;
  logic [3:0]         trail_q, trail_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               adv, adv_q;
`ifdef SQUARE1_AUTO_REVERSE_EN
  logic               rev_q, rev_d;
  logic               eff_dir;
`endif

  assign pause_s = sync_q[SYNC_STAGES-1][4];
  assign step_s  = sync_q[SYNC_STAGES-1][3];
  assign dir_s   = sync_q[SYNC_STAGES-1][2];
  assign speed_s = sync_q[SYNC_STAGES-1][1:0];

  // Multi-flop synchronizer for the asynchronous control inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.pause, bus.step, bus.dir, bus.speed};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Divider terminal count: one advance every 2^speed ticks
  always_comb begin
    div_lim = 3'((4'd1 << speed_s) - 4'd1);
    div_hit = (div_q >= div_lim);
  end

  // Next-state, divider, trail and frame update logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    trail_d = trail_q;
    adv     = 1'b0;
    frame_d = frame_q;
`ifdef SQUARE1_AUTO_REVERSE_EN
    rev_d   = rev_q;
    eff_dir = dir_s ^ rev_q;
`endif
    case (state_q)
      INTRO: begin
        if (bus.frame_tick) begin
          if (N_LAG == 1) begin
            state_d = RUN;
          end else if (div_hit) begin
            adv   = 1'b1;
            div_d = '0;
            if (trail_q < 4'(N_LAG)) trail_d = trail_q + 4'd1;
            if (trail_q + 4'd1 >= 4'(N_LAG)) state_d = RUN;
          end else begin
            div_d = div_q + 3'd1;
          end
        end
      end
      RUN: begin
        if (bus.frame_tick) begin
          if (pause_s) begin
            state_d = PAUSED;
          end else if (div_hit) begin
            adv   = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + 3'd1;
          end
        end
      end
      PAUSED: begin
        if (bus.frame_tick) begin
          if (!pause_s) state_d = RUN;
          else if (step_req) adv = 1'b1;
        end
      end
      default: begin
        state_d = INTRO;
        trail_d = 4'd1;
      end
    endcase

    if (adv) begin
`ifdef SQUARE1_AUTO_REVERSE_EN
      if (!eff_dir) begin
        if (&frame_q) begin
          frame_d = frame_q - FRAME_W'(1);
          rev_d   = ~rev_q;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end else begin
        if (frame_q == '0) begin
          frame_d = frame_q + FRAME_W'(1);
          rev_d   = ~rev_q;
        end else begin
          frame_d = frame_q - FRAME_W'(1);
        end
      end
`else
      frame_d = dir_s ? frame_q - FRAME_W'(1) : frame_q + FRAME_W'(1);
`endif
    end
  end

  // State register, counters, step request and registered advance pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INTRO;
      div_q     <= '0;
      trail_q   <= 4'd1;
      frame_q   <= '0;
      adv_q     <= 1'b0;
      step_prev <= 1'b0;
      step_req  <= 1'b0;
`ifdef SQUARE1_AUTO_REVERSE_EN
      rev_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      trail_q   <= trail_d;
      frame_q   <= frame_d;
      adv_q     <= adv;
      step_prev <= step_s;
      // every tick drops a pending step, used or not
      if (bus.frame_tick)           step_req <= 1'b0;
      else if (step_s && !step_prev) step_req <= 1'b1;
`ifdef SQUARE1_AUTO_REVERSE_EN
      rev_q     <= rev_d;
`endif
    end
  end

  assign bus.frame_no  = frame_q;
  assign bus.trail_len = trail_q;
  assign bus.advance   = adv_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_square1_anim_sequencer.sv
// Directed bench for the animation sequencer: intro growth, speed divider,
// pause / single-step, down wrap (or bounce), async reset, input sync.
`timescale 1ns/1ps
module tb_square1_anim_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  square1_anim_sequencer_if #(.FRAME_W(9)) bus();

  square1_anim_sequencer #(
    .FRAME_W(9),
    .N_LAG(15),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   ill_cnt = 0;
  logic adv_at, adv_after;

  // watch for the unused encoding on the state output
  always @(negedge clk) if (bus.state === 2'd3) ill_cnt++;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle frame_tick; records advance on the tick edge and the edge after
  task automatic do_tick();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    adv_at = bus.advance;
    @(negedge clk) adv_after = bus.advance;
    idle(2);
  endtask

  task automatic test_reset();
    bus.frame_tick = 1'b0; bus.pause = 1'b0; bus.step = 1'b0;
    bus.dir = 1'b0; bus.speed = 2'd0;
    rst_n = 1'b0;
    idle(3);
    checks++; if (bus.frame_no !== 9'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", bus.frame_no); end
    checks++; if (bus.trail_len !== 4'd1) begin errors++; $display("FAIL reset_trail got %0d want 1", bus.trail_len); end
    checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL reset_adv got %b want 0", bus.advance); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    @(negedge clk) rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_intro();
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      checks++; if (adv_at !== 1'b1) begin errors++; $display("FAIL intro_adv t%0d got %b want 1", k, adv_at); end
      checks++; if (adv_after !== 1'b0) begin errors++; $display("FAIL intro_adv_width t%0d got %b want 0", k, adv_after); end
      checks++; if (bus.frame_no !== 9'(k)) begin errors++; $display("FAIL intro_frame t%0d got %0d want %0d", k, bus.frame_no, k); end
      checks++; if (bus.trail_len !== 4'((k + 1 > 15) ? 15 : k + 1)) begin errors++; $display("FAIL intro_trail t%0d got %0d want %0d", k, bus.trail_len, (k + 1 > 15) ? 15 : k + 1); end
      checks++; if (bus.state !== ((k >= 14) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL intro_state t%0d got %0d want %0d", k, bus.state, (k >= 14) ? 1 : 0); end
    end
  endtask

  task automatic test_speed();
    int n_adv = 0;
    bus.speed = 2'd2;
    idle(3);
    for (int t = 1; t <= 12; t++) begin
      do_tick();
      if (adv_at === 1'b1) n_adv++;
      checks++; if (adv_at !== (t % 4 == 0)) begin errors++; $display("FAIL speed_adv t%0d got %b want %b", t, adv_at, (t % 4 == 0)); end
    end
    checks++; if (n_adv != 3) begin errors++; $display("FAIL speed_count got %0d want 3", n_adv); end
    checks++; if (bus.frame_no !== 9'd23) begin errors++; $display("FAIL speed_frame got %0d want 23", bus.frame_no); end
  endtask

  task automatic test_pause_step();
    bus.speed = 2'd0;
    idle(3);
    repeat (17) do_tick();
    checks++; if (bus.frame_no !== 9'd40) begin errors++; $display("FAIL ps_start got %0d want 40", bus.frame_no); end
    bus.pause = 1'b1;
    idle(3);
    do_tick();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL ps_enter_state got %0d want 2", bus.state); end
    checks++; if (adv_at !== 1'b0) begin errors++; $display("FAIL ps_enter_adv got %b want 0", adv_at); end
    for (int i = 0; i < 5; i++) begin
      do_tick();
      checks++; if (bus.frame_no !== 9'd40) begin errors++; $display("FAIL ps_hold t%0d got %0d want 40", i, bus.frame_no); end
    end
    bus.step = 1'b1; idle(3); bus.step = 1'b0; idle(3);
    bus.step = 1'b1; idle(3); bus.step = 1'b0; idle(3);
    do_tick();
    checks++; if (bus.frame_no !== 9'd41) begin errors++; $display("FAIL ps_step got %0d want 41", bus.frame_no); end
    checks++; if (adv_at !== 1'b1) begin errors++; $display("FAIL ps_step_adv got %b want 1", adv_at); end
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL ps_step_state got %0d want 2", bus.state); end
    do_tick();
    checks++; if (bus.frame_no !== 9'd41) begin errors++; $display("FAIL ps_step_once got %0d want 41", bus.frame_no); end
    bus.pause = 1'b0;
    idle(3);
    do_tick();
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL ps_resume_state got %0d want 1", bus.state); end
    checks++; if (adv_at !== 1'b0) begin errors++; $display("FAIL ps_resume_adv got %b want 0", adv_at); end
    checks++; if (bus.frame_no !== 9'd41) begin errors++; $display("FAIL ps_resume_frame got %0d want 41", bus.frame_no); end
    do_tick();
    checks++; if (bus.frame_no !== 9'd42) begin errors++; $display("FAIL ps_run_frame got %0d want 42", bus.frame_no); end
  endtask

  task automatic test_down_wrap();
    int exp_f [3];
`ifdef SQUARE1_AUTO_REVERSE_EN
    exp_f = '{0, 1, 2};
`else
    exp_f = '{0, 511, 510};
`endif
    bus.dir = 1'b1;
    idle(3);
    repeat (41) do_tick();
    checks++; if (bus.frame_no !== 9'd1) begin errors++; $display("FAIL dw_start got %0d want 1", bus.frame_no); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++; if (bus.frame_no !== 9'(exp_f[i])) begin errors++; $display("FAIL dw_frame t%0d got %0d want %0d", i, bus.frame_no, exp_f[i]); end
    end
  endtask

  task automatic test_async_reset();
`ifdef SQUARE1_AUTO_REVERSE_EN
    repeat (298) do_tick();
`else
    repeat (210) do_tick();
`endif
    checks++; if (bus.frame_no !== 9'd300) begin errors++; $display("FAIL ar_start got %0d want 300", bus.frame_no); end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL ar_start_state got %0d want 1", bus.state); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.frame_no !== 9'd0) begin errors++; $display("FAIL ar_frame got %0d want 0", bus.frame_no); end
    checks++; if (bus.trail_len !== 4'd1) begin errors++; $display("FAIL ar_trail got %0d want 1", bus.trail_len); end
    checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL ar_adv got %b want 0", bus.advance); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL ar_state got %0d want 0", bus.state); end
    bus.dir = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL ar_rel_state got %0d want 0", bus.state); end
    checks++; if (bus.trail_len !== 4'd1) begin errors++; $display("FAIL ar_rel_trail got %0d want 1", bus.trail_len); end
    do_tick();
    checks++; if (bus.frame_no !== 9'd1) begin errors++; $display("FAIL ar_intro_frame got %0d want 1", bus.frame_no); end
    checks++; if (bus.trail_len !== 4'd2) begin errors++; $display("FAIL ar_intro_trail got %0d want 2", bus.trail_len); end
  endtask

  task automatic test_input_sync();
    repeat (13) do_tick();
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL is_run got %0d want 1", bus.state); end
    checks++; if (bus.frame_no !== 9'd14) begin errors++; $display("FAIL is_frame got %0d want 14", bus.frame_no); end
    @(negedge clk);
    #3 bus.pause = 1'b1;
    #4 bus.pause = 1'b0;
    idle(4);
    do_tick();
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL is_glitch_state got %0d want 1", bus.state); end
    checks++; if (bus.frame_no !== 9'd15) begin errors++; $display("FAIL is_glitch_frame got %0d want 15", bus.frame_no); end
    checks++; if (ill_cnt != 0) begin errors++; $display("FAIL is_state3 got %0d want 0", ill_cnt); end
  endtask

  initial begin
    test_reset();
    test_intro();
    test_speed();
    test_pause_step();
    test_down_wrap();
    test_async_reset();
    test_input_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // guard against a runaway simulation
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
